// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared widths, read-packer state encoding and clog2 helper.
// Revision    : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int c_dsize = 8;
    localparam int c_asize = 4;

    localparam logic [0:0] c_st_fill = 1'b0;
    localparam logic [0:0] c_st_hold = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) width = i + 1;
        end
        return width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_flush_timer.sv
`default_nettype none
// ============================================================================
// Module      : rd_flush_timer
// Description : Saturating idle counter; expire fires on the cycle it reaches TIMEOUT.
// Revision    : 1.0  initial release
// ============================================================================
module rd_flush_timer
    import fifo_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic clear,
    output logic expire
);

    localparam int              c_tw   = clog2(TIMEOUT + 1);
    localparam logic [c_tw-1:0] c_max  = c_tw'(TIMEOUT);
    localparam logic [c_tw-1:0] c_last = c_tw'(TIMEOUT - 1);

    logic [c_tw-1:0] r_timer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer <= '0;
        end else if (clear) begin
            r_timer <= '0;
        end else if (arm && (r_timer != c_max)) begin
            r_timer <= r_timer + c_tw'(1);
        end
    end

    // Fires on the armed cycle that takes the count to TIMEOUT, so the beat is out next cycle.
    assign expire = arm && (r_timer >= c_last);

endmodule
`default_nettype wire

// File: rtl/fifo_read_packer.sv
`default_nettype none
// ============================================================================
// Module      : fifo_read_packer
// Description : Pops FIFO words and packs PACK of them into a valid/ready beat.
// Revision    : 1.0  initial release
// ============================================================================
module fifo_read_packer
    import fifo_pkg::*;
#(
    parameter int DSIZE   = c_dsize,
    parameter int PACK    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                         rclk,
    input  logic                         rrst,
    input  logic [DSIZE-1:0]             rdata,
    input  logic                         rempty,
    output logic                         rinc,
    output logic [DSIZE*PACK-1:0]        out_data,
    output logic [PACK-1:0]              out_keep,
    output logic                         out_valid,
    input  logic                         out_ready,
    input  logic                         flush_req,
    output logic [clog2(PACK+1)-1:0]     lane_cnt
);

    localparam int              c_lw   = clog2(PACK + 1);
    localparam logic [c_lw-1:0] c_pack = c_lw'(PACK);

    logic [0:0]      r_state, w_state_nxt;
    logic [c_lw-1:0] r_lane_cnt, w_lane_nxt, w_filled;
    logic [PACK-1:0] r_keep, w_keep_nxt, w_lane_sel;
    logic            w_empty, w_pop, w_handshake, w_to_hold, w_arm, w_clear, w_expire;

    // Reset forces empty so the pop strobe is held low and never X during reset.
    assign w_empty     = rempty | rrst;
    assign w_pop       = !w_empty && ((r_state == c_st_fill) || out_ready);
    assign w_filled    = r_lane_cnt + c_lw'(w_pop);
    assign w_handshake = (r_state == c_st_hold) && out_ready;
    assign w_arm       = (r_state == c_st_fill) && (r_lane_cnt != '0) && w_empty && !flush_req;
    assign w_clear     = w_pop || flush_req || w_to_hold;

    always_comb begin
        w_state_nxt = r_state;
        w_lane_nxt  = r_lane_cnt;
        w_keep_nxt  = r_keep;
        w_to_hold   = 1'b0;
        if (r_state == c_st_fill) begin
            w_lane_nxt = w_filled;
            if ((w_filled == c_pack) || ((w_filled != '0) && (flush_req || w_expire))) begin
                w_to_hold   = 1'b1;
                w_state_nxt = c_st_hold;
                for (int i = 0; i < PACK; i++) begin
                    w_keep_nxt[i] = (c_lw'(i) < w_filled);
                end
            end
        end else if (out_ready) begin
            w_state_nxt = c_st_fill;
            w_lane_nxt  = c_lw'(w_pop);
            w_keep_nxt  = '0;
        end
    end

    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            r_state    <= c_st_fill;
            r_lane_cnt <= '0;
            r_keep     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lane_cnt <= w_lane_nxt;
            r_keep     <= w_keep_nxt;
        end
    end

    // Each lane owns its register; a handshake clears all lanes, refilling lane 0 if popping.
    for (genvar i = 0; i < PACK; i++) begin : g_lane
        logic [DSIZE-1:0] r_word;

        assign w_lane_sel[i] = (r_lane_cnt == c_lw'(i));

        always_ff @(posedge rclk or posedge rrst) begin
            if (rrst) begin
                r_word <= '0;
            end else if (w_handshake) begin
                r_word <= ((i == 0) && w_pop) ? rdata : '0;
            end else if ((r_state == c_st_fill) && w_pop && w_lane_sel[i]) begin
                r_word <= rdata;
            end
        end

        assign out_data[i*DSIZE +: DSIZE] = r_word;
    end

    if (TIMEOUT > 0) begin : g_timer
        rd_flush_timer #(
            .TIMEOUT (TIMEOUT)
        ) u_timer (
            .clk    (rclk),
            .rst    (rrst),
            .arm    (w_arm),
            .clear  (w_clear),
            .expire (w_expire)
        );
    end else begin : g_no_timer
        assign w_expire = 1'b0;
    end

    assign rinc      = w_pop;
    assign out_valid = (r_state == c_st_hold);
    assign out_keep  = r_keep;
    assign lane_cnt  = r_lane_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_read_packer
// Description : Directed vectors plus scoreboarded random traffic for PACK=4 and PACK=2.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_read_packer;

    localparam int c_words = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rrst;
    logic [7:0]  rdata1, rdata2;
    logic        rempty1, rempty2, rinc1, rinc2;
    logic        ready1, ready2, flush1, flush2, valid1, valid2;
    logic [31:0] data1;
    logic [15:0] data2;
    logic [3:0]  keep1;
    logic [1:0]  keep2;
    logic [2:0]  lane1;
    logic [1:0]  lane2;

    fifo_read_packer #(.DSIZE(8), .PACK(4), .TIMEOUT(16)) dut (
        .rclk(clk), .rrst(rrst), .rdata(rdata1), .rempty(rempty1), .rinc(rinc1),
        .out_data(data1), .out_keep(keep1), .out_valid(valid1), .out_ready(ready1),
        .flush_req(flush1), .lane_cnt(lane1)
    );

    fifo_read_packer #(.DSIZE(8), .PACK(2), .TIMEOUT(3)) dut2 (
        .rclk(clk), .rrst(rrst), .rdata(rdata2), .rempty(rempty2), .rinc(rinc2),
        .out_data(data2), .out_keep(keep2), .out_valid(valid2), .out_ready(ready2),
        .flush_req(flush2), .lane_cnt(lane2)
    );

    typedef struct packed {
        logic        empty;
        logic [7:0]  din;
        logic        ready;
        logic        flush;
        logic        rinc;
        logic        valid;
        logic [3:0]  keep;
        logic [31:0] data;
        logic [2:0]  lane;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    int          src1, src2, got1, got2, n;
    logic        hold1, hold2;
    logic [3:0]  hkeep1;
    logic [1:0]  hkeep2;
    logic [31:0] hdata1;
    logic [15:0] hdata2;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic addv(input logic e, input logic [7:0] d, input logic r, input logic f,
                        input logic ri, input logic va, input logic [3:0] ke,
                        input logic [31:0] da, input logic [2:0] la);
        vec_t v;
        v = '{e, d, r, f, ri, va, ke, da, la};
        vecs.push_back(v);
    endtask

    function automatic int lead_ones(input logic [3:0] k);
        int c = 0;
        for (int i = 0; i < 4; i++) if (k[i] && (c == i)) c = i + 1;
        return c;
    endfunction

    function automatic logic [3:0] mask_of(input int cnt);
        return 4'((1 << cnt) - 1);
    endfunction

    function automatic logic [31:0] beat_of(input int base, input int cnt);
        logic [31:0] b = '0;
        for (int k = 0; k < cnt; k++) b[k*8 +: 8] = 8'(base + k);
        return b;
    endfunction

    // Entered at the first empty cycle after the last pop; beat must appear on cycle 17.
    task automatic timeout_seq(input string name, input logic [31:0] exp_data,
                               input logic [3:0] exp_keep, input logic [2:0] exp_lane);
        logic early = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            if (valid1 !== 1'b0) early = 1'b1;
            @(negedge clk);
        end
        #1;
        chk({name, "_early"}, 64'(early), 64'd0);
        chk(name, {valid1, keep1, data1, lane1}, {1'b1, exp_keep, exp_data, exp_lane});
    endtask

    initial begin
        rrst = 1'b1;
        rempty1 = 1'b1; rdata1 = '0; ready1 = 1'b0; flush1 = 1'b0;
        rempty2 = 1'b1; rdata2 = '0; ready2 = 1'b0; flush2 = 1'b0;

        // empty din rdy flush | rinc valid keep data lane
        addv(0, 8'h11, 1, 0, 1, 0, 4'h0, 32'h00000000, 3'd0);
        addv(0, 8'h22, 1, 0, 1, 0, 4'h0, 32'h00000011, 3'd1);
        addv(0, 8'h33, 1, 0, 1, 0, 4'h0, 32'h00002211, 3'd2);
        addv(0, 8'h44, 1, 0, 1, 0, 4'h0, 32'h00332211, 3'd3);
        addv(1, 8'h00, 1, 0, 0, 1, 4'hF, 32'h44332211, 3'd4);
        addv(1, 8'h00, 1, 0, 0, 0, 4'h0, 32'h00000000, 3'd0);
        addv(0, 8'h11, 0, 0, 1, 0, 4'h0, 32'h00000000, 3'd0);
        addv(0, 8'h22, 0, 0, 1, 0, 4'h0, 32'h00000011, 3'd1);
        addv(0, 8'h33, 0, 0, 1, 0, 4'h0, 32'h00002211, 3'd2);
        addv(0, 8'h44, 0, 0, 1, 0, 4'h0, 32'h00332211, 3'd3);
        addv(0, 8'h55, 0, 0, 0, 1, 4'hF, 32'h44332211, 3'd4);
        addv(0, 8'h55, 0, 0, 0, 1, 4'hF, 32'h44332211, 3'd4);
        addv(0, 8'h55, 1, 0, 1, 1, 4'hF, 32'h44332211, 3'd4);
        addv(0, 8'h66, 1, 0, 1, 0, 4'h0, 32'h00000055, 3'd1);
        addv(0, 8'h77, 1, 0, 1, 0, 4'h0, 32'h00006655, 3'd2);
        addv(0, 8'h88, 1, 0, 1, 0, 4'h0, 32'h00776655, 3'd3);
        addv(1, 8'h00, 0, 0, 0, 1, 4'hF, 32'h88776655, 3'd4);
        addv(1, 8'h00, 1, 0, 0, 1, 4'hF, 32'h88776655, 3'd4);
        addv(1, 8'h00, 0, 0, 0, 0, 4'h0, 32'h00000000, 3'd0);
        addv(0, 8'hB1, 0, 1, 1, 0, 4'h0, 32'h00000000, 3'd0);
        addv(1, 8'h00, 0, 0, 0, 1, 4'h1, 32'h000000B1, 3'd1);
        addv(1, 8'h00, 0, 1, 0, 1, 4'h1, 32'h000000B1, 3'd1);
        addv(1, 8'h00, 1, 0, 0, 1, 4'h1, 32'h000000B1, 3'd1);
        addv(1, 8'h00, 1, 1, 0, 0, 4'h0, 32'h00000000, 3'd0);
        addv(1, 8'h00, 0, 0, 0, 0, 4'h0, 32'h00000000, 3'd0);

        repeat (3) @(negedge clk);
        rempty1 = 1'b0; rempty2 = 1'b0;
        #1;
        chk("reset_state1", {rinc1, valid1, keep1, data1, lane1}, 64'd0);
        chk("reset_state2", {rinc2, valid2, keep2, data2, lane2}, 64'd0);
        rempty1 = 1'b1; rempty2 = 1'b1;
        @(negedge clk);
        rrst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            rempty1 = vecs[i].empty; rdata1 = vecs[i].din;
            ready1  = vecs[i].ready; flush1 = vecs[i].flush;
            #1;
            chk($sformatf("vec%0d", i), {rinc1, valid1, keep1, data1, lane1},
                {vecs[i].rinc, vecs[i].valid, vecs[i].keep, vecs[i].data, vecs[i].lane});
        end

        // idle timeout on a two-word partial beat, then again after returning to FILL
        @(negedge clk); rempty1 = 1'b0; rdata1 = 8'hA1; ready1 = 1'b0; flush1 = 1'b0;
        @(negedge clk); rdata1 = 8'hA2;
        @(negedge clk); rempty1 = 1'b1;
        timeout_seq("timeout_a", 32'h0000A2A1, 4'h3, 3'd2);
        ready1 = 1'b1;
        @(negedge clk); ready1 = 1'b0;
        #1 chk("after_timeout_hs", {valid1, keep1, lane1}, 64'd0);
        repeat (20) @(negedge clk);
        #1 chk("idle_lane0_no_beat", 64'(valid1), 64'd0);
        rempty1 = 1'b0; rdata1 = 8'hC1;
        @(negedge clk); rempty1 = 1'b1;
        timeout_seq("timeout_c", 32'h000000C1, 4'h1, 3'd1);
        ready1 = 1'b1;
        @(negedge clk); ready1 = 1'b0;

        // asynchronous reset with a partial beat, then with a pending beat
        @(negedge clk); rempty1 = 1'b0; rdata1 = 8'h01;
        @(negedge clk); rdata1 = 8'h02;
        @(negedge clk); rdata1 = 8'h03;
        @(negedge clk); rempty1 = 1'b1;
        #1 chk("pre_reset_lane", 64'(lane1), 64'd3);
        #2 rrst = 1'b1; rempty1 = 1'b0;
        #1 chk("reset_mid_fill", {rinc1, valid1, keep1, data1, lane1}, 64'd0);
        rempty1 = 1'b1;
        @(negedge clk); rrst = 1'b0;
        @(negedge clk); rempty1 = 1'b0; rdata1 = 8'h05;
        @(negedge clk); rdata1 = 8'h06;
        @(negedge clk); rdata1 = 8'h07;
        @(negedge clk); rdata1 = 8'h08;
        @(negedge clk); rempty1 = 1'b1;
        #1 chk("pre_reset_hold", {valid1, keep1, data1}, {1'b1, 4'hF, 32'h08070605});
        #2 rrst = 1'b1; rempty1 = 1'b0; ready1 = 1'b1;
        #1 chk("reset_mid_hold", {rinc1, valid1, keep1, data1, lane1}, 64'd0);
        rempty1 = 1'b1; ready1 = 1'b0;
        @(negedge clk); rrst = 1'b0;
        @(negedge clk);
        #1 chk("post_reset", {valid1, keep1, lane1}, 64'd0);

        // random traffic on both widths with an in-order word scoreboard
        src1 = 0; src2 = 0; got1 = 0; got2 = 0;
        hold1 = 1'b0; hold2 = 1'b0; hkeep1 = '0; hkeep2 = '0; hdata1 = '0; hdata2 = '0;
        for (int cyc = 0; cyc < 60000; cyc++) begin
            if ((got1 >= c_words) && (got2 >= c_words)) break;
            @(negedge clk);
            rempty1 = (src1 >= c_words) || ($urandom_range(0, 3) == 0);
            rdata1  = 8'(src1);
            ready1  = ($urandom_range(0, 3) != 0);
            flush1  = ($urandom_range(0, 19) == 0);
            rempty2 = (src2 >= c_words) || ($urandom_range(0, 3) == 0);
            rdata2  = 8'(src2);
            ready2  = ($urandom_range(0, 3) != 0);
            flush2  = ($urandom_range(0, 19) == 0);
            #1;
            if (hold1) chk("stable1", {valid1, keep1, data1}, {1'b1, hkeep1, hdata1});
            if (valid1 && ready1) begin
                n = lead_ones(keep1);
                chk("keep1", 64'((keep1 == mask_of(n)) && (n > 0)), 64'd1);
                chk("beat1", 64'(data1), 64'(beat_of(got1, n)));
                got1 += n;
            end
            hold1 = valid1 && !ready1; hkeep1 = keep1; hdata1 = data1;
            if (rinc1) src1++;

            if (hold2) chk("stable2", {valid2, keep2, data2}, {1'b1, hkeep2, hdata2});
            if (valid2 && ready2) begin
                n = lead_ones({2'b00, keep2});
                chk("keep2", 64'(({2'b00, keep2} == mask_of(n)) && (n > 0)), 64'd1);
                chk("beat2", 64'(data2), 64'(16'(beat_of(got2, n))));
                got2 += n;
            end
            hold2 = valid2 && !ready2; hkeep2 = keep2; hdata2 = data2;
            if (rinc2) src2++;
        end
        chk("words1", 64'(got1), 64'(c_words));
        chk("words2", 64'(got2), 64'(c_words));
        chk("popped1", 64'(src1), 64'(c_words));
        chk("popped2", 64'(src2), 64'(c_words));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
